// File: rtl/prog_branch_lut_pkg.sv
// Shared types, constants and target arithmetic for the programmable branch-offset LUT.
package prog_branch_lut_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } lut_state_t;

    // Every entry starts as a plain sequential advance.
    localparam int DEFAULT_ENTRY = 1;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] sext_add(
        input logic [MAX_W-1:0] pc,
        input logic [MAX_W-1:0] off,
        input int               off_w
    );
        logic [MAX_W-1:0] ext;
        ext = off;
        for (int b = 0; b < MAX_W; b++) begin
            if (b >= off_w) begin
                ext[b] = off[off_w-1];
            end
        end
        return pc + ext;
    endfunction

endpackage

// File: rtl/prog_branch_lut_lut_mem.sv
// Flat offset storage for all banks: one synchronous write port, one combinational read port.
module lut_mem
    import prog_branch_lut_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_branch_lut.sv
// Programmable multi-bank branch-offset LUT with a registered lookup returning offset and PC target.
module prog_branch_lut
    import prog_branch_lut_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int OUT_W = 10,
    parameter int BANKS = 2,
    parameter int PC_W  = 10,
    localparam int BK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             RdEn,
    input  logic [BK_W-1:0]  Bank,
    input  logic [IDX_W-1:0] Index,
    input  logic [PC_W-1:0]  PC,
    output logic [OUT_W-1:0] Out,
    output logic [PC_W-1:0]  Target,
    output logic             OutValid,
    input  logic             WrEn,
    input  logic [BK_W-1:0]  WrBank,
    input  logic [IDX_W-1:0] WrIndex,
    input  logic [OUT_W-1:0] WrData,
    output logic             WrReady,
    input  logic             Init,
    output logic             Busy
);

    localparam int DEPTH  = 2**IDX_W;
    localparam int TOTAL  = BANKS * DEPTH;
    localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    lut_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [OUT_W-1:0]  out_q;
    logic [PC_W-1:0]   target_q;
    logic              outValid_q;
    logic              wrReady_q;
    logic              busy_q;

    logic              rdBankOk;
    logic              wrBankOk;
    logic              userWe;
    logic              memWe;
    logic              bypass;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] memWaddr;
    logic [OUT_W-1:0]  memWdata;
    logic [OUT_W-1:0]  memRdata;
    logic [OUT_W-1:0]  out_d;
    logic [PC_W-1:0]   target_d;

    // Out-of-range banks only exist when BANKS is not a power of two; they read as zero offset.
    always_comb begin
        rdBankOk = int'(Bank) < BANKS;
        wrBankOk = int'(WrBank) < BANKS;
        rdAddr   = rdBankOk ? ADDR_W'(int'(Bank) * DEPTH + int'(Index)) : '0;
        wrAddr   = wrBankOk ? ADDR_W'(int'(WrBank) * DEPTH + int'(WrIndex)) : '0;
        userWe   = (state_q == IDLE) && WrEn && wrReady_q && !Init && wrBankOk;
        memWe    = (state_q == INIT) || userWe;
        memWaddr = (state_q == INIT) ? cnt_q : wrAddr;
        memWdata = (state_q == INIT) ? OUT_W'(DEFAULT_ENTRY) : WrData;
        bypass   = userWe && rdBankOk && (WrBank == Bank) && (WrIndex == Index);
        if (!rdBankOk) begin
            out_d = '0;
        end else if (bypass) begin
            out_d = WrData;
        end else begin
            out_d = memRdata;
        end
        target_d = PC_W'(sext_add(MAX_W'(PC), MAX_W'(out_d), OUT_W));
    end

    lut_mem #(
        .ENTRIES (TOTAL),
        .ADDR_W  (ADDR_W),
        .DATA_W  (OUT_W)
    ) u_mem (
        .clk_i   (Clk),
        .we_i    (memWe),
        .waddr_i (memWaddr),
        .wdata_i (memWdata),
        .raddr_i (rdAddr),
        .rdata_o (memRdata)
    );

    // Init restarts the default walk from entry 0 whichever state it arrives in.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            out_q      <= '0;
            target_q   <= '0;
            outValid_q <= 1'b0;
            wrReady_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    if (Init) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        wrReady_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (RdEn) begin
                        out_q      <= out_d;
                        target_q   <= target_d;
                        outValid_q <= 1'b1;
                    end
                    if (Init) begin
                        state_q   <= INIT;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        wrReady_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign Out      = out_q;
    assign Target   = target_q;
    assign OutValid = outValid_q;
    assign WrReady  = wrReady_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_prog_branch_lut.sv
// Scoreboard bench for prog_branch_lut: directed lookups push expected results, a monitor checks them.
module tb_prog_branch_lut;

    localparam int IDX_W = 4;
    localparam int OUT_W = 10;
    localparam int BANKS = 2;
    localparam int PC_W  = 10;
    localparam int BK_W  = 1;

    typedef struct packed {
        logic [OUT_W-1:0] out;
        logic [PC_W-1:0]  target;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             RdEn;
    logic [BK_W-1:0]  Bank;
    logic [IDX_W-1:0] Index;
    logic [PC_W-1:0]  PC;
    logic [OUT_W-1:0] Out;
    logic [PC_W-1:0]  Target;
    logic             OutValid;
    logic             WrEn;
    logic [BK_W-1:0]  WrBank;
    logic [IDX_W-1:0] WrIndex;
    logic [OUT_W-1:0] WrData;
    logic             WrReady;
    logic             Init;
    logic             Busy;

    exp_t expQ[$];
    exp_t monExp;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    always #5 Clk = ~Clk;

    prog_branch_lut #(
        .IDX_W (IDX_W),
        .OUT_W (OUT_W),
        .BANKS (BANKS),
        .PC_W  (PC_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .RdEn     (RdEn),
        .Bank     (Bank),
        .Index    (Index),
        .PC       (PC),
        .Out      (Out),
        .Target   (Target),
        .OutValid (OutValid),
        .WrEn     (WrEn),
        .WrBank   (WrBank),
        .WrIndex  (WrIndex),
        .WrData   (WrData),
        .WrReady  (WrReady),
        .Init     (Init),
        .Busy     (Busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drives one clock of stimulus, then returns every request line to idle.
    task automatic applyStimulus(
        input logic             rd,
        input logic [BK_W-1:0]  bk,
        input logic [IDX_W-1:0] idx,
        input logic [PC_W-1:0]  pc,
        input logic             wr,
        input logic [BK_W-1:0]  wbk,
        input logic [IDX_W-1:0] widx,
        input logic [OUT_W-1:0] wdata,
        input logic             ini
    );
        RdEn = rd; Bank = bk; Index = idx; PC = pc;
        WrEn = wr; WrBank = wbk; WrIndex = widx; WrData = wdata;
        Init = ini;
        @(posedge Clk);
        #1;
        RdEn = 1'b0; WrEn = 1'b0; Init = 1'b0;
    endtask

    task automatic expectRead(input logic [OUT_W-1:0] o, input logic [PC_W-1:0] t);
        exp_t e;
        e.out    = o;
        e.target = t;
        expQ.push_back(e);
    endtask

    task automatic readAt(input logic [BK_W-1:0] bk, input logic [IDX_W-1:0] idx,
                          input logic [PC_W-1:0] pc, input logic [OUT_W-1:0] o,
                          input logic [PC_W-1:0] t);
        expectRead(o, t);
        applyStimulus(1'b1, bk, idx, pc, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic writeAt(input logic [BK_W-1:0] bk, input logic [IDX_W-1:0] idx,
                           input logic [OUT_W-1:0] d);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, bk, idx, d, 1'b0);
    endtask

    task automatic countBusy(output int cnt);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 100) begin
            @(posedge Clk);
            #1;
            cnt++;
        end
    endtask

    // Every valid lookup must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Reset === 1'b1 && OutValid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid actual Out=%0d Target=%0d required no lookup", Out, Target);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("read_out", 32'(Out), 32'(monExp.out));
                checkOutput("read_target", 32'(Target), 32'(monExp.target));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        RdEn = 1'b0; Bank = '0; Index = '0; PC = '0;
        WrEn = 1'b0; WrBank = '0; WrIndex = '0; WrData = '0;
        Init = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_out", 32'(Out), 0);
        checkOutput("rst_target", 32'(Target), 0);
        checkOutput("rst_valid", 32'(OutValid), 0);
        checkOutput("rst_wrready", 32'(WrReady), 0);
        checkOutput("rst_busy", 32'(Busy), 1);

        Reset = 1'b1;
        countBusy(n);
        checkOutput("boot_busy_cycles", n, 32);
        checkOutput("boot_wrready", 32'(WrReady), 1);

        readAt(1'b1, 4'd7, 10'd100, 10'd1, 10'd101);

        writeAt(1'b0, 4'd0, 10'h28E);
        readAt(1'b0, 4'd0, 10'd400, 10'h28E, 10'd30);
        readAt(1'b1, 4'd0, 10'd0, 10'd1, 10'd1);

        writeAt(1'b0, 4'd15, 10'h29B);
        readAt(1'b0, 4'd15, 10'd5, 10'h29B, 10'd672);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("hold_valid", 32'(OutValid), 0);
        checkOutput("hold_out", 32'(Out), 32'h29B);
        checkOutput("hold_target", 32'(Target), 672);

        expectRead(10'd42, 10'd52);
        applyStimulus(1'b1, 1'b0, 4'd3, 10'd10, 1'b1, 1'b0, 4'd3, 10'd42, 1'b0);
        readAt(1'b0, 4'd3, 10'd1000, 10'd42, 10'd18);

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 4'd1, 10'd99, 1'b1);
        checkOutput("init_busy", 32'(Busy), 1);
        checkOutput("init_wrready", 32'(WrReady), 0);
        writeAt(1'b1, 4'd2, 10'd77);
        countBusy(n);
        checkOutput("init_busy_cycles", n + 1, 32);
        checkOutput("init_done_wrready", 32'(WrReady), 1);
        readAt(1'b0, 4'd0, 10'd400, 10'd1, 10'd401);
        readAt(1'b0, 4'd15, 10'd5, 10'd1, 10'd6);
        readAt(1'b0, 4'd3, 10'd10, 10'd1, 10'd11);
        readAt(1'b0, 4'd1, 10'd20, 10'd1, 10'd21);
        readAt(1'b1, 4'd2, 10'd30, 10'd1, 10'd31);

        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(Busy), 1);
        checkOutput("midrst_out", 32'(Out), 0);
        checkOutput("midrst_target", 32'(Target), 0);
        checkOutput("midrst_wrready", 32'(WrReady), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        RdEn = 1'b1; Bank = 1'b1; Index = 4'd7; PC = 10'd3;
        n = 0;
        do begin
            @(posedge Clk);
            #1;
            n++;
            checkOutput("busy_read_ignored", 32'(OutValid), 0);
        end while (Busy === 1'b1 && n < 100);
        RdEn = 1'b0;
        checkOutput("midrst_busy_cycles", n, 32);

        readAt(1'b1, 4'd15, 10'd1023, 10'd1, 10'd0);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        checkOutput("queue_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
